// File: rtl/afu_flr_seq_pkg.sv
// Shared types for the FLR quiesce sequencer: FSM state encoding and request payload.
package afu_flr_seq_pkg;

  localparam int unsigned FLR_PF_W = 3;
  localparam int unsigned FLR_VF_W = 11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    HOLD,
    RESP
  } t_flr_seq_state;

  typedef struct packed {
    logic [FLR_PF_W-1:0] pf;
    logic [FLR_VF_W-1:0] vf;
    logic                vf_active;
  } t_flr_req;

endpackage

// File: rtl/afu_flr_quiesce_seq_if.sv
// FLR request/response handshake between the FLR path (master) and the sequencer (slave).
interface afu_flr_quiesce_seq_if #(
  parameter int unsigned PF_W = 3,
  parameter int unsigned VF_W = 11
) ();

  logic            flr_req_valid;
  logic            flr_req_ready;
  logic [PF_W-1:0] flr_req_pf;
  logic [VF_W-1:0] flr_req_vf;
  logic            flr_req_vf_active;

  logic            flr_rsp_valid;
  logic            flr_rsp_ready;
  logic [PF_W-1:0] flr_rsp_pf;
  logic [VF_W-1:0] flr_rsp_vf;
  logic            flr_rsp_vf_active;

  modport master (
    output flr_req_valid, flr_req_pf, flr_req_vf, flr_req_vf_active, flr_rsp_ready,
    input  flr_req_ready, flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active
  );

  modport slave (
    input  flr_req_valid, flr_req_pf, flr_req_vf, flr_req_vf_active, flr_rsp_ready,
    output flr_req_ready, flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active
  );

endinterface

// File: rtl/axis_pkt_boundary_trk.sv
// One-bit "inside a packet" tracker for a monitored AXI-S TX port, with synchronous clear.
module axis_pkt_boundary_trk (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic in_pkt_nxt_c_o
);

  logic in_pkt_q;
  logic in_pkt_d;

  // A handshake beat sets the flag unless it is the last beat; clear wins.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (tvalid_i && tready_i) begin
      in_pkt_d = !tlast_i;
    end
    if (clr_i) begin
      in_pkt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt_nxt_c_o = in_pkt_d;

endmodule

// File: rtl/afu_flr_quiesce_seq.sv
// FLR sequencer: maps one PF/VF FLR to its AFU ports, drains TX at a packet boundary,
// holds the port reset for a fixed time, then returns the FLR completion.
module afu_flr_quiesce_seq #(
  parameter int unsigned                    NUM_PORTS      = 4,
  parameter int unsigned                    PF_W           = 3,
  parameter int unsigned                    VF_W           = 11,
  parameter logic [NUM_PORTS-1:0][PF_W-1:0] PORT_PF        = '0,
  parameter logic [NUM_PORTS-1:0][VF_W-1:0] PORT_VF        = '0,
  parameter logic [NUM_PORTS-1:0]           PORT_VF_ACTIVE = '0,
  parameter int unsigned                    RST_HOLD       = 16,
  parameter int unsigned                    DRAIN_TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  afu_flr_quiesce_seq_if.slave      flr_if,
  input  logic [NUM_PORTS-1:0]      port_tx_tvalid_i,
  input  logic [NUM_PORTS-1:0]      port_tx_tready_i,
  input  logic [NUM_PORTS-1:0]      port_tx_tlast_i,
  output logic [NUM_PORTS-1:0]      port_tx_block_o,
  output logic [NUM_PORTS-1:0]      port_rst_o,
  output logic                      drain_timeout_o
);

  import afu_flr_seq_pkg::*;

  localparam int unsigned TMR_MAX = (RST_HOLD > DRAIN_TIMEOUT) ? RST_HOLD : DRAIN_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RST_HOLD - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_TOP    = TMR_W'(TMR_MAX);

  t_flr_seq_state state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [PF_W-1:0] req_pf_q, req_pf_d;
  logic [VF_W-1:0] req_vf_q, req_vf_d;
  logic            req_vfa_q, req_vfa_d;
  logic [NUM_PORTS-1:0] match_q, match_d;

  logic [NUM_PORTS-1:0] port_rst_q, port_rst_d;
  logic [NUM_PORTS-1:0] block_q, block_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_PORTS-1:0] req_match;
  logic [NUM_PORTS-1:0] in_pkt_nxt;
  logic                 req_fire;
  logic                 drained;
  logic                 drain_exp;

  // A PF FLR takes the PF and every VF under it; a VF FLR only the exact VF port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign req_match[p] = (PORT_PF[p] == flr_if.flr_req_pf) &&
                          (!flr_if.flr_req_vf_active ||
                           (PORT_VF_ACTIVE[p] && (PORT_VF[p] == flr_if.flr_req_vf)));

    axis_pkt_boundary_trk u_trk (
      .clk            (clk),
      .rst            (rst),
      .clr_i          (port_rst_q[p]),
      .tvalid_i       (port_tx_tvalid_i[p]),
      .tready_i       (port_tx_tready_i[p]),
      .tlast_i        (port_tx_tlast_i[p]),
      .in_pkt_nxt_c_o (in_pkt_nxt[p])
    );
  end

  assign req_fire = ready_q && flr_if.flr_req_valid;
  // Looking at the post-beat value lets HOLD start right after the closing tlast beat.
  assign drained   = ((in_pkt_nxt & match_q) == '0);
  assign drain_exp = (timer_q == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      timer_q     <= '0;
      req_pf_q    <= '0;
      req_vf_q    <= '0;
      req_vfa_q   <= 1'b0;
      match_q     <= '0;
      port_rst_q  <= '1;
      block_q     <= '1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_pf_q    <= req_pf_d;
      req_vf_q    <= req_vf_d;
      req_vfa_q   <= req_vfa_d;
      match_q     <= match_d;
      port_rst_q  <= port_rst_d;
      block_q     <= block_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next state, request capture and the shared INIT/DRAIN/HOLD timer.
  always_comb begin : p_next
    state_d   = state_q;
    req_pf_d  = req_pf_q;
    req_vf_d  = req_vf_q;
    req_vfa_d = req_vfa_q;
    match_d   = match_q;
    timer_d   = timer_q;
    case (state_q)
      INIT:  if (timer_q == HOLD_LAST) state_d = IDLE;
      IDLE: begin
        if (req_fire) begin
          req_pf_d  = flr_if.flr_req_pf;
          req_vf_d  = flr_if.flr_req_vf;
          req_vfa_d = flr_if.flr_req_vf_active;
          match_d   = req_match;
          state_d   = (req_match == '0) ? RESP : DRAIN;
        end
      end
      DRAIN: if (drained || drain_exp) state_d = HOLD;
      HOLD:  if (timer_q == HOLD_LAST) state_d = RESP;
      RESP:  if (flr_if.flr_rsp_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TMR_TOP) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin : p_out
    port_rst_d  = '0;
    block_d     = '0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    tmo_d       = (state_q == DRAIN) && !drained && drain_exp;
    case (state_d)
      INIT: begin
        port_rst_d = '1;
        block_d    = '1;
      end
      IDLE:  ready_d = 1'b1;
      DRAIN: block_d = match_d;
      HOLD: begin
        block_d    = match_d;
        port_rst_d = match_d;
      end
      RESP:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  assign flr_if.flr_req_ready     = ready_q;
  assign flr_if.flr_rsp_valid     = rsp_valid_q;
  assign flr_if.flr_rsp_pf        = req_pf_q;
  assign flr_if.flr_rsp_vf        = req_vf_q;
  assign flr_if.flr_rsp_vf_active = req_vfa_q;
  assign port_tx_block_o          = block_q;
  assign port_rst_o               = port_rst_q;
  assign drain_timeout_o          = tmo_q;

endmodule

// File: tb/tb_afu_flr_quiesce_seq.sv
// Directed bench for afu_flr_quiesce_seq: reset/INIT, VF and PF FLR, drain, timeout,
// zero-match back-pressure and reset during HOLD. Inputs change and outputs are sampled on negedge.
module tb_afu_flr_quiesce_seq;

  import afu_flr_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] tvalid = '0;
  logic [3:0] tready = '0;
  logic [3:0] tlast  = '0;
  logic [3:0] tx_block;
  logic [3:0] port_rst;
  logic       tmo;
  logic       rdy;
  logic       rspv;
  logic [2:0]  rsp_pf;
  logic [10:0] rsp_vf;
  logic        rsp_vfa;

  int checks   = 0;
  int failures = 0;

  afu_flr_quiesce_seq_if #(.PF_W(FLR_PF_W), .VF_W(FLR_VF_W)) flr_if ();

  // Ports 0..3: PF {0,0,1,0}, VF_ACTIVE {0,1,0,1}, VF {0,0,0,1}
  afu_flr_quiesce_seq #(
    .NUM_PORTS      (4),
    .PF_W           (3),
    .VF_W           (11),
    .PORT_PF        ({3'd0, 3'd1, 3'd0, 3'd0}),
    .PORT_VF        ({11'd1, 11'd0, 11'd0, 11'd0}),
    .PORT_VF_ACTIVE (4'b1010),
    .RST_HOLD       (16),
    .DRAIN_TIMEOUT  (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flr_if           (flr_if),
    .port_tx_tvalid_i (tvalid),
    .port_tx_tready_i (tready),
    .port_tx_tlast_i  (tlast),
    .port_tx_block_o  (tx_block),
    .port_rst_o       (port_rst),
    .drain_timeout_o  (tmo)
  );

  assign rdy     = flr_if.flr_req_ready;
  assign rspv    = flr_if.flr_rsp_valid;
  assign rsp_pf  = flr_if.flr_rsp_pf;
  assign rsp_vf  = flr_if.flr_rsp_vf;
  assign rsp_vfa = flr_if.flr_rsp_vf_active;

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input t_flr_req r, input logic v);
    flr_if.flr_req_valid     = v;
    flr_if.flr_req_pf        = r.pf;
    flr_if.flr_req_vf        = r.vf;
    flr_if.flr_req_vf_active = r.vf_active;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      tick();
      checks++;
      if ({port_rst, tx_block, rdy, rspv, tmo} !== {4'hf, 4'hf, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_vals got=%b exp=%b", {port_rst, tx_block, rdy, rspv, tmo}, 11'b11111111000);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({port_rst, tx_block, rdy} !== {4'hf, 4'hf, 1'b0}) begin
        failures++;
        $display("FAIL init_hold i=%0d got=%b exp=%b", i, {port_rst, tx_block, rdy}, 9'b111111110);
      end
      tick();
    end
    checks++;
    if ({port_rst, tx_block, rdy, rspv} !== {4'h0, 4'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL init_release got=%b exp=%b", {port_rst, tx_block, rdy, rspv}, 10'b0000000010);
    end
  endtask

  task automatic test_flr_idle_port(input string tag, input t_flr_req r, input logic [3:0] exp);
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%b exp=1", tag, rdy);
    end
    drive_req(r, 1'b1);
    tick();
    flr_if.flr_req_valid = 1'b0;
    checks++;
    if ({port_rst, tx_block, rdy, rspv} !== {4'h0, exp, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_drain got=%b exp=%b", tag, {port_rst, tx_block, rdy, rspv}, {4'h0, exp, 2'b00});
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({port_rst, tx_block, rspv} !== {exp, exp, 1'b0}) begin
        failures++;
        $display("FAIL %s_hold i=%0d got=%b exp=%b", tag, i, {port_rst, tx_block, rspv}, {exp, exp, 1'b0});
      end
      tick();
    end
    checks++;
    if ({port_rst, tx_block, rspv, rsp_pf, rsp_vf, rsp_vfa} !== {4'h0, 4'h0, 1'b1, r.pf, r.vf, r.vf_active}) begin
      failures++;
      $display("FAIL %s_resp got=%h exp=%h", tag, {port_rst, tx_block, rspv, rsp_pf, rsp_vf, rsp_vfa},
               {4'h0, 4'h0, 1'b1, r.pf, r.vf, r.vf_active});
    end
    flr_if.flr_rsp_ready = 1'b1;
    tick();
    flr_if.flr_rsp_ready = 1'b0;
    checks++;
    if ({rdy, rspv} !== 2'b10) begin
      failures++;
      $display("FAIL %s_ack got=%b exp=10", tag, {rdy, rspv});
    end
  endtask

  task automatic test_mid_packet();
    t_flr_req r = '{pf: 3'd0, vf: 11'd0, vf_active: 1'b1};
    tvalid[1] = 1'b1; tready[1] = 1'b1; tlast[1] = 1'b0;   // beat 1
    tick();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=1", rdy);
    end
    drive_req(r, 1'b1);                                    // beat 2 with the FLR
    tick();
    flr_if.flr_req_valid = 1'b0;                           // beat 3
    checks++;
    if ({port_rst, tx_block, tmo} !== {4'h0, 4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL mid_drain1 got=%b exp=%b", {port_rst, tx_block, tmo}, 9'b000000100);
    end
    tick();
    tlast[1] = 1'b1;                                       // beat 4, last
    checks++;
    if ({port_rst, tx_block, tmo} !== {4'h0, 4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL mid_drain2 got=%b exp=%b", {port_rst, tx_block, tmo}, 9'b000000100);
    end
    tick();
    tvalid[1] = 1'b0; tready[1] = 1'b0; tlast[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({port_rst, tx_block, tmo, rspv} !== {4'b0010, 4'b0010, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL mid_hold i=%0d got=%b exp=%b", i, {port_rst, tx_block, tmo, rspv}, 10'b0010001000);
      end
      tick();
    end
    checks++;
    if ({port_rst, tx_block, rspv, rsp_pf, rsp_vf, rsp_vfa} !== {4'h0, 4'h0, 1'b1, 3'd0, 11'd0, 1'b1}) begin
      failures++;
      $display("FAIL mid_resp got=%h", {port_rst, tx_block, rspv, rsp_pf, rsp_vf, rsp_vfa});
    end
    flr_if.flr_rsp_ready = 1'b1;
    tick();
    flr_if.flr_rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    t_flr_req r = '{pf: 3'd1, vf: 11'd0, vf_active: 1'b0};
    tvalid[2] = 1'b1; tready[2] = 1'b1; tlast[2] = 1'b0;   // SOP accepted, packet open
    tick();
    tready[2] = 1'b0;                                      // then stuck
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_ready got=%b exp=1", rdy);
    end
    drive_req(r, 1'b1);
    tick();
    flr_if.flr_req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({port_rst, tx_block, tmo} !== {4'h0, 4'b0100, 1'b0}) begin
        failures++;
        $display("FAIL tmo_drain i=%0d got=%b exp=%b", i, {port_rst, tx_block, tmo}, 9'b000001000);
      end
      tick();
    end
    // Pulse is registered at the DRAIN exit, so it shows in the first HOLD cycle.
    checks++;
    if ({port_rst, tx_block, tmo} !== {4'b0100, 4'b0100, 1'b1}) begin
      failures++;
      $display("FAIL tmo_pulse got=%b exp=%b", {port_rst, tx_block, tmo}, 9'b010001001);
    end
    tvalid[2] = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({port_rst, tx_block, tmo, rspv} !== {4'b0100, 4'b0100, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL tmo_hold i=%0d got=%b exp=%b", i, {port_rst, tx_block, tmo, rspv}, 10'b0100010000);
      end
      tick();
    end
    checks++;
    if ({port_rst, rspv, rsp_pf, rsp_vfa} !== {4'h0, 1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL tmo_resp got=%b", {port_rst, rspv, rsp_pf, rsp_vfa});
    end
    flr_if.flr_rsp_ready = 1'b1;
    tick();
    flr_if.flr_rsp_ready = 1'b0;
    // Tracker was cleared by the reset: a repeat FLR drains in one cycle.
    drive_req(r, 1'b1);
    tick();
    flr_if.flr_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({port_rst, tmo} !== {4'b0100, 1'b0}) begin
        failures++;
        $display("FAIL tmo_inpkt_clr i=%0d got=%b exp=%b", i, {port_rst, tmo}, 5'b01000);
      end
      tick();
    end
    flr_if.flr_rsp_ready = 1'b1;
    tick();
    flr_if.flr_rsp_ready = 1'b0;
    checks++;
    if ({rdy, rspv} !== 2'b10) begin
      failures++;
      $display("FAIL tmo_ack got=%b exp=10", {rdy, rspv});
    end
  endtask

  task automatic test_zero_match();
    t_flr_req r  = '{pf: 3'd7, vf: 11'h155, vf_active: 1'b0};
    t_flr_req r2 = '{pf: 3'd0, vf: 11'd0, vf_active: 1'b0};
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL zm_ready got=%b exp=1", rdy);
    end
    drive_req(r, 1'b1);
    tick();
    drive_req(r2, 1'b1);                                   // competing request, must wait
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if ({rspv, rdy, port_rst, tx_block, rsp_pf, rsp_vf, rsp_vfa} !==
          {1'b1, 1'b0, 4'h0, 4'h0, 3'd7, 11'h155, 1'b0}) begin
        failures++;
        $display("FAIL zm_stable i=%0d got=%h", i, {rspv, rdy, port_rst, tx_block, rsp_pf, rsp_vf, rsp_vfa});
      end
      if (i < 10) tick();
    end
    flr_if.flr_req_valid = 1'b0;
    flr_if.flr_rsp_ready = 1'b1;
    tick();
    flr_if.flr_rsp_ready = 1'b0;
    checks++;
    if ({rdy, rspv, port_rst, rsp_pf} !== {1'b1, 1'b0, 4'h0, 3'd7}) begin
      failures++;
      $display("FAIL zm_ack got=%b exp=%b", {rdy, rspv, port_rst, rsp_pf}, 9'b100000111);
    end
  endtask

  task automatic test_rst_during_hold();
    t_flr_req r = '{pf: 3'd0, vf: 11'd0, vf_active: 1'b0};
    drive_req(r, 1'b1);
    tick();
    flr_if.flr_req_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (port_rst !== 4'b1011) begin
      failures++;
      $display("FAIL rh_in_hold got=%b exp=1011", port_rst);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({port_rst, tx_block, rdy, rspv} !== {4'hf, 4'hf, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rh_reset got=%b exp=%b", {port_rst, tx_block, rdy, rspv}, 10'b1111111100);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({port_rst, rspv, rdy} !== {4'hf, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rh_init i=%0d got=%b exp=%b", i, {port_rst, rspv, rdy}, 6'b111100);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({port_rst, tx_block, rdy, rspv} !== {4'h0, 4'h0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL rh_idle i=%0d got=%b exp=%b", i, {port_rst, tx_block, rdy, rspv}, 10'b0000000010);
      end
      tick();
    end
  endtask

  initial begin
    flr_if.flr_req_valid     = 1'b0;
    flr_if.flr_req_pf        = '0;
    flr_if.flr_req_vf        = '0;
    flr_if.flr_req_vf_active = 1'b0;
    flr_if.flr_rsp_ready     = 1'b0;
    test_reset();
    test_flr_idle_port("vf_flr", '{pf: 3'd0, vf: 11'd1, vf_active: 1'b1}, 4'b1000);
    test_flr_idle_port("pf_flr", '{pf: 3'd0, vf: 11'h7ff, vf_active: 1'b0}, 4'b1011);
    test_mid_packet();
    test_timeout();
    test_zero_match();
    test_rst_during_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
